// File: rtl/hdmi_out_pkg.sv
// Shared types and constants for the hdmi_out fill path.
package hdmi_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int RD_LEN_W       = 8;

  // Byte distance between consecutive burst start addresses.
  function automatic logic [31:0] burst_bytes(input int words, input int data_w);
    return 32'(words * (data_w / 8));
  endfunction

endpackage

// File: rtl/fill_fifo_reader.sv
// Reads one half-FIFO worth of words from DDR as fixed-length bursts and
// pushes every returned beat into the pixel FIFO.
module fill_fifo_reader
  import hdmi_out_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int BURST_WORDS    = 16,
  parameter int WORDS_PER_FILL = 160
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go_fill_fifo,
  input  logic [31:0]         ddr_addr_to_read,
  output logic                fill_busy,
  output logic                fill_done,
  output logic                fill_err,
  output logic                go_overrun,
  output logic                rd_req,
  output logic [31:0]         rd_addr,
  output logic [RD_LEN_W-1:0] rd_len,
  input  logic                rd_ack,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_data_valid,
  input  logic                rd_last,
  input  logic                rd_err,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_wr_data
);

  localparam int          WORD_CNT_W = $clog2(WORDS_PER_FILL + 1);
  localparam logic [31:0] ADDR_STEP  = burst_bytes(BURST_WORDS, DATA_W);

  fill_state_e             state_r;
  logic [RD_LEN_W-1:0]     beat_cnt_r;
  logic [WORD_CNT_W-1:0]   word_cnt_r;
  logic                    fill_busy_r;
  logic                    fill_done_r;
  logic                    fill_err_r;
  logic                    go_overrun_r;
  logic                    rd_req_r;
  logic [31:0]             rd_addr_r;
  logic [RD_LEN_W-1:0]     rd_len_r;
  logic                    fifo_wr_en_r;
  logic [DATA_W-1:0]       fifo_wr_data_r;

  logic                    burst_end_s;
  logic                    words_left_s;
  logic                    early_last_s;

  // Burst/fill boundary decode for the beat arriving this cycle.
  always_comb begin
    burst_end_s  = 1'b0;
    words_left_s = 1'b0;
    early_last_s = 1'b0;
    if (beat_cnt_r == RD_LEN_W'(BURST_WORDS - 1)) begin
      burst_end_s = 1'b1;
    end else begin
      burst_end_s = 1'b0;
    end
    if (word_cnt_r < WORD_CNT_W'(WORDS_PER_FILL - 1)) begin
      words_left_s = 1'b1;
    end else begin
      words_left_s = 1'b0;
    end
    if (rd_last && !burst_end_s) begin
      early_last_s = 1'b1;
    end else begin
      early_last_s = 1'b0;
    end
  end

  // Fill sequencer: request bursts, forward beats, report completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      beat_cnt_r     <= '0;
      word_cnt_r     <= '0;
      fill_busy_r    <= 1'b0;
      fill_done_r    <= 1'b0;
      fill_err_r     <= 1'b0;
      go_overrun_r   <= 1'b0;
      rd_req_r       <= 1'b0;
      rd_addr_r      <= 32'h0000_0000;
      rd_len_r       <= '0;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= '0;
    end else begin
      fifo_wr_en_r <= 1'b0;
      fill_done_r  <= 1'b0;
      if (go_fill_fifo && (state_r != ST_IDLE)) begin
        go_overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (go_fill_fifo) begin
            rd_addr_r   <= ddr_addr_to_read;
            rd_len_r    <= RD_LEN_W'(BURST_WORDS);
            beat_cnt_r  <= '0;
            word_cnt_r  <= '0;
            fill_err_r  <= 1'b0;
            fill_busy_r <= 1'b1;
            rd_req_r    <= !fifo_full;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_err) begin
            rd_req_r    <= 1'b0;
            fill_err_r  <= 1'b1;
            fill_done_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (rd_req_r && rd_ack) begin
            rd_req_r   <= 1'b0;
            beat_cnt_r <= '0;
            state_r    <= ST_DATA;
          end else if (!rd_req_r) begin
            // Once raised, the request is held until accepted.
            rd_req_r <= !fifo_full;
          end
        end
        ST_DATA: begin
          if (rd_data_valid) begin
            if (fifo_full) begin
              fill_err_r <= 1'b1;
            end else begin
              fifo_wr_en_r   <= 1'b1;
              fifo_wr_data_r <= rd_data;
            end
            beat_cnt_r <= beat_cnt_r + RD_LEN_W'(1);
            word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
          end
          if (rd_err || (rd_data_valid && early_last_s)) begin
            fill_err_r  <= 1'b1;
            fill_done_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (rd_data_valid && burst_end_s) begin
            if (words_left_s) begin
              rd_addr_r <= rd_addr_r + ADDR_STEP;
              rd_req_r  <= !fifo_full;
              state_r   <= ST_REQ;
            end else begin
              fill_done_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          fill_busy_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          rd_req_r    <= 1'b0;
          fill_busy_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign fill_busy    = fill_busy_r;
  assign fill_done    = fill_done_r;
  assign fill_err     = fill_err_r;
  assign go_overrun   = go_overrun_r;
  assign rd_req       = rd_req_r;
  assign rd_addr      = rd_addr_r;
  assign rd_len       = rd_len_r;
  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;

endmodule

// File: tb/tb_fill_fifo_reader.sv
// Randomized bench: acts as the DDR responder and compares FIFO pushes,
// burst addresses and status against a transaction-level expectation.
module tb_fill_fifo_reader;

  localparam int BURST = 16;
  localparam int NB    = 10;
  localparam int STEP  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_fill_fifo;
  logic [31:0] ddr_addr_to_read;
  logic        fill_busy, fill_done, fill_err, go_overrun;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_data_valid, rd_last, rd_err, fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;

  int num_checks = 0;
  int num_fails  = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int done_cnt  = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  fill_fifo_reader #(.DATA_W(32), .BURST_WORDS(BURST), .WORDS_PER_FILL(160)) dut (
    .clk(clk), .reset(reset), .go_fill_fifo(go_fill_fifo),
    .ddr_addr_to_read(ddr_addr_to_read), .fill_busy(fill_busy),
    .fill_done(fill_done), .fill_err(fill_err), .go_overrun(go_overrun),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last),
    .rd_err(rd_err), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data)
  );

  always #5 clk = ~clk;

  // Collect pushes, done pulses and request rising edges.
  always @(negedge clk) begin
    if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    if (fill_done) done_cnt++;
    if (rd_req && !req_prev) req_rises++;
    req_prev = rd_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_fill(input logic [31:0] a, input int ack_lat, input int err_burst,
                          input int err_beat, input int last_burst, input int full_burst,
                          input bit full_req, input int go_burst);
    bit  exp_err = 1'b0;
    bit  stop    = 1'b0;
    int  b       = 0;
    int  waited;
    int  mism    = 0;
    logic [31:0] exp_a;
    got_q.delete(); exp_q.delete(); done_cnt = 0; req_rises = 0;
    go_fill_fifo = 1'b1; ddr_addr_to_read = a; fifo_full = full_req;
    @(negedge clk);
    go_fill_fifo = 1'b0;
    check("busy_after_go", 32'(fill_busy), 32'd1);
    if (full_req) begin
      repeat (3) begin
        check("req_held_by_full", 32'(rd_req), 32'd0);
        @(negedge clk);
      end
      fifo_full = 1'b0;
    end
    while (!stop && b < NB) begin
      waited = 0;
      while (!rd_req && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!rd_req) begin
        check("req_timeout", 32'd0, 32'd1);
        stop = 1'b1;
      end else begin
        exp_a = a + 32'(b * STEP);
        check("rd_addr", rd_addr, exp_a);
        check("rd_len", 32'(rd_len), 32'(BURST));
        repeat (ack_lat - 1) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int j = 0; j < BURST && !stop; j++) begin
          logic [31:0] d;
          d = $urandom;
          rd_data_valid = 1'b1;
          rd_data       = d;
          rd_err        = (b == err_burst && j == err_beat);
          rd_last       = (j == BURST - 1) || (b == last_burst && j == BURST - 2);
          fifo_full     = (b == full_burst && j < 3);
          go_fill_fifo  = (b == go_burst && j == 2);
          if (fifo_full) exp_err = 1'b1;
          else exp_q.push_back(d);
          if (rd_err || (b == last_burst && j == BURST - 2)) begin
            exp_err = 1'b1;
            stop    = 1'b1;
          end
          @(negedge clk);
        end
        rd_data_valid = 1'b0; rd_last = 1'b0; rd_err = 1'b0;
        fifo_full = 1'b0; go_fill_fifo = 1'b0;
        if (stop) check("done_after_abort", 32'(fill_done), 32'd1);
        b++;
      end
    end
    repeat (5) @(negedge clk);
    check("push_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) mism++;
    check("push_data", 32'(mism), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("fill_err", 32'(fill_err), 32'(exp_err));
    check("busy_end", 32'(fill_busy), 32'd0);
    check("req_count", 32'(req_rises), 32'(b));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b0; go_fill_fifo = 1'b0; ddr_addr_to_read = 32'h0;
    rd_ack = 1'b0; rd_data = 32'h0; rd_data_valid = 1'b0;
    rd_last = 1'b0; rd_err = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_req", 32'(rd_req), 32'd0);
    check("rst_addr", rd_addr, 32'd0);
    check("rst_len", 32'(rd_len), 32'd0);
    check("rst_wr", 32'(fifo_wr_en), 32'd0);
    check("rst_flags", 32'({fill_done, fill_err, go_overrun}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_fill(32'hA800_0000, 2, -1, -1, -1, -1, 1'b0, -1);
    run_fill(32'hFFFF_FFC0, $urandom_range(3, 1), -1, -1, -1, -1, 1'b0, -1);
    run_fill(32'h1234_5600, $urandom_range(3, 1), 2, 4, -1, -1, 1'b0, -1);
    check("pushes_on_err", 32'(got_q.size()), 32'd37);
    run_fill(32'h0000_4000, $urandom_range(3, 1), -1, -1, -1, 0, 1'b1, -1);
    check("pushes_on_full", 32'(got_q.size()), 32'd157);
    run_fill($urandom & 32'hFFFF_FFC0, $urandom_range(3, 1), -1, -1, -1, -1, 1'b0, -1);
    check("overrun_clear", 32'(go_overrun), 32'd0);
    run_fill(32'h2000_0000, $urandom_range(3, 1), -1, -1, 3, -1, 1'b0, 1);
    check("overrun_set", 32'(go_overrun), 32'd1);

    // Reset in the middle of a burst.
    go_fill_fifo = 1'b1; ddr_addr_to_read = 32'h0000_1000;
    @(negedge clk);
    go_fill_fifo = 1'b0;
    waited = 0;
    while (!rd_req && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("rst_test_req", 32'(rd_req), 32'd1);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    for (int j = 0; j < 5; j++) begin
      rd_data_valid = 1'b1; rd_data = $urandom;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("async_busy", 32'(fill_busy), 32'd0);
    check("async_wr", 32'(fifo_wr_en), 32'd0);
    check("async_data", fifo_wr_data, 32'd0);
    check("async_addr", rd_addr, 32'd0);
    check("async_flags", 32'({rd_req, fill_done, fill_err, go_overrun}), 32'd0);
    got_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      rd_data = $urandom;
      @(negedge clk);
    end
    rd_data_valid = 1'b0;
    @(negedge clk);
    check("idle_ignores_beats", 32'(got_q.size()), 32'd0);
    check("idle_busy", 32'(fill_busy), 32'd0);
    run_fill(32'h3000_0040, $urandom_range(3, 1), -1, -1, -1, -1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule
